// File: rtl/tone_player_pkg.sv
// tone_pkg: note codes, base half-period table and FSM state type for tone_player.
package tone_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } tone_state_e;

    // Half-period in 100 MHz clocks for each note; rests return 0.
    function automatic logic [31:0] base_half(input logic [3:0] note);
        case (note)
            NOTE_DO:  return 32'd191113;
            NOTE_RE:  return 32'd170262;
            NOTE_MI:  return 32'd151686;
            NOTE_FA:  return 32'd143172;
            NOTE_SOL: return 32'd127551;
            NOTE_LA:  return 32'd113636;
            NOTE_SI:  return 32'd101238;
            default:  return 32'd0;
        endcase
    endfunction

    // Codes 0 and 8..15 play silence.
    function automatic logic is_rest(input logic [3:0] note);
        return (note == NOTE_REST) || (note > NOTE_SI);
    endfunction

endpackage

// File: rtl/tone_player_if.sv
// tone_player_if: request handshake, abort, outputs and debug state of tone_player.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; the requester holds its fields stable while valid is
// high and not yet accepted; req_ready never depends on req_valid.
interface tone_player_if #(
    parameter int DUR_W = 16
);
    import tone_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_note;
    logic [2:0]       req_oct;
    logic [DUR_W-1:0] req_dur;
    logic             abort;
    logic             speaker;
    logic             busy;
    logic             note_done;
    tone_state_e      dbg_state;

    modport master (
        output req_valid, req_note, req_oct, req_dur, abort,
        input  req_ready, speaker, busy, note_done, dbg_state
    );

    modport slave (
        input  req_valid, req_note, req_oct, req_dur, abort,
        output req_ready, speaker, busy, note_done, dbg_state
    );

endinterface

// File: rtl/tone_tick_gen.sv
// tone_tick_gen: duration prescaler, one-cycle tick every TICK_DIV clocks after clear.
module tone_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Count 0..TICK_DIV-1 and wrap; clear restarts the tick phase.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_player.sv
// tone_player: sequenced square-wave tone generator, one note per handshake.
// Optional silent gap after each note is built when TONE_GAP_EN is defined.
module tone_player
    import tone_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int DUR_W         = 16,
    parameter int TICK_DIV      = 100000,
    parameter int SIM_DIV_SHIFT = 0,
    parameter int GAP_TICKS     = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_player_if.slave  bus
);
    tone_state_e      state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
    logic             rest_q, rest_d;
    logic             spk_q, spk_d;
    logic             done_q, done_d;
    logic             tick, tick_clr;
    logic             req_ready, accept;
    logic [CNT_W-1:0] base_h, h_calc;
    logic [CNT_W+3:0] wide;
    logic [2:0]       lamt;
`ifdef TONE_GAP_EN
    logic [31:0]      gap_cnt_q, gap_cnt_d;
`else
    logic             unused_gap_cfg;
    assign unused_gap_cfg = (GAP_TICKS > 0);
`endif

    // Ready is withheld during reset and while abort is asserted.
    assign req_ready     = rst_n && (state_q == ST_IDLE) && !bus.abort;
    assign accept        = bus.req_valid && req_ready;
    assign bus.req_ready = req_ready;
    assign bus.speaker   = spk_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.note_done = done_q;
    assign bus.dbg_state = state_q;

    tone_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (tick_clr),
        .tick_o  (tick)
    );

    // Half-period for the presented request: scaled base, octave shift, min 1.
    always_comb begin
        base_h = CNT_W'(base_half(bus.req_note) >> SIM_DIV_SHIFT);
        wide   = '0;
        lamt   = 3'd0;
        h_calc = base_h;
        if (!bus.req_oct[2]) begin
            h_calc = base_h >> bus.req_oct;
        end else begin
            lamt   = 3'd0 - bus.req_oct;
            wide   = {4'b0000, base_h} << lamt;
            h_calc = (|wide[CNT_W+3:CNT_W]) ? '1 : wide[CNT_W-1:0];
        end
        if (h_calc == '0) begin
            h_calc = CNT_W'(1);
        end
    end

    // Next-state and datapath: accept, play with duration count, optional gap, abort.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        h_d       = h_q;
        dur_d     = dur_q;
        dur_cnt_d = dur_cnt_q;
        rest_d    = rest_q;
        spk_d     = spk_q;
        done_d    = 1'b0;
        tick_clr  = 1'b0;
`ifdef TONE_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tick_clr = 1'b1;
                if (accept) begin
                    state_d   = ST_PLAY;
                    h_d       = h_calc;
                    dur_d     = bus.req_dur;
                    rest_d    = is_rest(bus.req_note);
                    phase_d   = '0;
                    dur_cnt_d = '0;
                    spk_d     = 1'b0;
                end
            end
            ST_PLAY: begin
                if ((dur_q == '0) || (tick && (dur_cnt_q == dur_q - DUR_W'(1)))) begin
                    spk_d     = 1'b0;
                    phase_d   = '0;
                    dur_cnt_d = '0;
`ifdef TONE_GAP_EN
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    tick_clr  = 1'b1;
`else
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
`endif
                end else begin
                    if (tick) begin
                        dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    end
                    if (phase_q == h_q - CNT_W'(1)) begin
                        phase_d = '0;
                        spk_d   = rest_q ? 1'b0 : ~spk_q;
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
            end
`ifdef TONE_GAP_EN
            ST_GAP: begin
                if ((GAP_TICKS <= 0) || (tick && (gap_cnt_q + 32'd1 >= 32'(GAP_TICKS)))) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                end else if (tick) begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.abort) begin
            state_d   = ST_IDLE;
            spk_d     = 1'b0;
            phase_d   = '0;
            dur_cnt_d = '0;
            done_d    = 1'b0;
            tick_clr  = 1'b1;
`ifdef TONE_GAP_EN
            gap_cnt_d = '0;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            h_q       <= CNT_W'(1);
            dur_q     <= '0;
            dur_cnt_q <= '0;
            rest_q    <= 1'b0;
            spk_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef TONE_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            h_q       <= h_d;
            dur_q     <= dur_d;
            dur_cnt_q <= dur_cnt_d;
            rest_q    <= rest_d;
            spk_q     <= spk_d;
            done_q    <= done_d;
`ifdef TONE_GAP_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: self-checking bench for tone_player with a cycle-level waveform model.
module tb_tone_player;
    import tone_pkg::*;

    localparam int TD    = 1000;
    localparam int SHIFT = 10;
    localparam int DW    = 16;
    localparam int GAPT  = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    tone_player_if #(.DUR_W(DW)) bus ();

    tone_player #(
        .CNT_W(32), .DUR_W(DW), .TICK_DIV(TD), .SIM_DIV_SHIFT(SHIFT), .GAP_TICKS(GAPT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference half-period from the note table, octave rule and clamp.
    function automatic longint ref_half(input int note, input int oct);
        longint tab[8];
        longint h;
        tab = '{64'd0, 64'd191113, 64'd170262, 64'd151686, 64'd143172,
                64'd127551, 64'd113636, 64'd101238};
        if (note < 1 || note > 7) return 1;
        h = tab[note] >> SHIFT;
        if (oct > 0) begin
            h = h >> oct;
        end else if (oct < 0) begin
            h = h * (longint'(1) << (-oct));
            if (h > 64'hFFFF_FFFF) h = 64'hFFFF_FFFF;
        end
        if (h < 1) h = 1;
        return h;
    endfunction

    function automatic bit ref_rest(input int note);
        return (note < 1) || (note > 7);
    endfunction

    // Present a request and wait (bounded) for the accepting edge.
    task automatic send_req(input int note, input int oct, input int dur);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_note  = 4'(note);
        bus.req_oct   = 3'(oct);
        bus.req_dur   = DW'(dur);
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.req_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        bus.req_valid = 1'b0;
        bus.req_note  = 4'($urandom_range(15));
        bus.req_oct   = 3'($urandom_range(7));
        bus.req_dur   = DW'($urandom_range(65535));
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept_timeout: req_ready never 1 within 100 cycles, required 1");
        end
    endtask

    // Check a note cycle by cycle from the cycle after acceptance up to note_done.
    task automatic check_note(input int note, input int oct, input int dur);
        longint h;
        int d, d_busy, bad, first_bad, rise1, rise2;
        logic prev;
        logic [0:0] e;
        h = ref_half(note, oct);
        d = dur * TD;
        d_busy = (dur == 0) ? 1 : d;
        bad = 0; first_bad = -1; rise1 = -1; rise2 = -1; prev = 1'b0;
        exp_q.delete();
        for (int k = 0; k < d_busy; k++) begin
            if (ref_rest(note) || k >= d) exp_q.push_back(1'b0);
            else exp_q.push_back(1'((k / h) % 2));
        end
        for (int k = 0; k < d_busy; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (bus.speaker !== e[0] || bus.busy !== 1'b1 || bus.note_done !== 1'b0 ||
                bus.req_ready !== 1'b0) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (bus.speaker === 1'b1 && prev === 1'b0) begin
                if (rise1 < 0) rise1 = k;
                else if (rise2 < 0) rise2 = k;
            end
            prev = bus.speaker;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL play_wave note=%0d oct=%0d dur=%0d: %0d bad cycles, first at %0d, required 0",
                     note, oct, dur, bad, first_bad);
        end
        if (!ref_rest(note) && d > 3 * h) begin
            n_cmp++;
            if (rise1 != h || (rise2 - rise1) != 2 * h) begin
                n_err++;
                $display("FAIL period note=%0d oct=%0d: first rise %0d period %0d, required %0d / %0d",
                         note, oct, rise1, rise2 - rise1, h, 2 * h);
            end
        end
`ifdef TONE_GAP_EN
        bad = 0;
        for (int k = 0; k < GAPT * TD; k++) begin
            @(negedge clk);
            if (bus.speaker !== 1'b0 || bus.busy !== 1'b1 || bus.note_done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL gap_wave: %0d bad cycles, required 0", bad);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (bus.note_done !== 1'b1 || bus.busy !== 1'b0 || bus.speaker !== 1'b0 ||
            bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL note_end: done=%b busy=%b spk=%b ready=%b, required 1 0 0 1",
                     bus.note_done, bus.busy, bus.speaker, bus.req_ready);
        end
    endtask

    task automatic check_done_low();
        @(negedge clk);
        n_cmp++;
        if (bus.note_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_single: done=%b busy=%b, required 0 0", bus.note_done, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.abort = 1'b0;
        bus.req_note = 4'd0; bus.req_oct = 3'd0; bus.req_dur = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.speaker !== 1'b0 || bus.busy !== 1'b0 || bus.note_done !== 1'b0 ||
            bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: spk=%b busy=%b done=%b ready=%b, required 0 0 0 0",
                     bus.speaker, bus.busy, bus.note_done, bus.req_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_release: ready=%b state=%0d, required 1 0",
                     bus.req_ready, bus.dbg_state);
        end
    endtask

    task automatic test_tone_basic();
        send_req(1, 0, 3);
        check_note(1, 0, 3);
        check_done_low();
    endtask

    task automatic test_octaves();
        send_req(1, 1, 2);
        check_note(1, 1, 2);
        send_req(1, -1, 2);
        check_note(1, -1, 2);
        send_req(7, -4, 7);
        check_note(7, -4, 7);
    endtask

    task automatic test_rest();
        send_req(0, 0, 2);
        check_note(0, 0, 2);
        send_req(12, 2, 1);
        check_note(12, 2, 1);
        check_done_low();
    endtask

    task automatic test_dur_zero();
        send_req(1, 0, 0);
        check_note(1, 0, 0);
        check_done_low();
    endtask

    task automatic test_back_to_back();
        send_req(1, 1, 2);
        bus.req_valid = 1'b1;
        bus.req_note  = 4'd4;
        bus.req_oct   = 3'(-1);
        bus.req_dur   = DW'(1);
        check_note(1, 1, 2);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_note(4, -1, 1);
        check_done_low();
    endtask

    task automatic test_abort();
        int seen;
        send_req(3, 0, 3);
        repeat (500) @(negedge clk);
        bus.abort     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_note  = 4'd5;
        bus.req_dur   = DW'(1);
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0 || bus.speaker !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre: ready=%b spk=%b, required 0 1", bus.req_ready, bus.speaker);
        end
        @(posedge clk);
        #1;
        bus.abort     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.speaker !== 1'b0 || bus.note_done !== 1'b0 ||
            bus.dbg_state !== ST_IDLE || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_idle: busy=%b spk=%b done=%b state=%0d ready=%b, required 0 0 0 0 1",
                     bus.busy, bus.speaker, bus.note_done, bus.dbg_state, bus.req_ready);
        end
        seen = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.note_done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_quiet: %0d cycles busy or done, required 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        send_req(2, 0, 3);
        repeat (600) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.speaker !== 1'b0 || bus.busy !== 1'b0 || bus.note_done !== 1'b0 ||
            bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: spk=%b busy=%b done=%b ready=%b, required 0 0 0 0",
                     bus.speaker, bus.busy, bus.note_done, bus.req_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_ready: ready=%b, required 1", bus.req_ready);
        end
        check_done_low();
    endtask

    task automatic test_random();
        int note, oct, dur;
        for (int i = 0; i < 8; i++) begin
            note = $urandom_range(15);
            oct  = int'($urandom_range(7)) - 4;
            dur  = $urandom_range(3);
            send_req(note, oct, dur);
            check_note(note, oct, dur);
        end
        check_done_low();
    endtask

    initial begin
        test_reset();
        test_tone_basic();
        test_octaves();
        test_rest();
        test_dur_zero();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tone_player.md
# tone_player

Parametrised, sequenced square-wave tone generator for the buzzer output. It accepts one note request at a time over a valid/ready handshake: a note code, a signed octave shift and a duration. It plays the tone for exactly that duration, then pulses `note_done`. It sits between the song/autoplay sequencers and the speaker pin, and replaces free-running tone generation with per-note timing, a wider octave range and an abort path.

## Interface
- `CNT_W`, 32: half-period counter width.
- `DUR_W`, 16: duration field width, in ticks.
- `TICK_DIV`, 100000: clocks per duration tick (1 ms at 100 MHz); must be ≥1.
- `SIM_DIV_SHIFT`, 0: base half-periods are right-shifted by this before the octave shift; used by benches only.
- `GAP_TICKS`, 20: silent ticks after each note; only used with `TONE_GAP_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  a request is presented.
- `req_ready`  out  1  the block can accept a request.
- `req_note`  in  4  note code: 1..7 = do..si; 0 and 8..15 = rest.
- `req_oct`  in  3  signed octave shift, −4..+3; positive = higher pitch.
- `req_dur`  in  DUR_W  note length in ticks.
- `abort`  in  1  stop the current note immediately.
- `speaker`  out  1  square-wave output.
- `busy`  out  1  a note or gap is in progress.
- `note_done`  out  1  one-cycle pulse when a note completes normally.

## Operation
- States: IDLE, PLAY, and GAP (GAP exists only with the macro). `req_ready` = (state==IDLE) && !abort.
- Accept on a clock edge where `req_valid && req_ready`. The note, octave and duration are latched at that edge, so inputs may change afterwards.
- Half-period H:
  - Start from base[note] >> SIM_DIV_SHIFT.
  - oct > 0: shift right by oct. oct < 0: shift left by |oct|, saturating to all-ones on overflow.
  - Clamp H to a minimum of 1.
- PLAY, tone note: the phase counter runs 0..H−1; `speaker` toggles on wrap, giving a period of exactly 2H clocks with 50% duty.
- PLAY, rest note: `speaker` is held 0.
- Duration: a prescaler emits a tick every TICK_DIV clocks, counted from acceptance. After the `req_dur`-th tick:
  - `speaker` is forced to 0.
  - The state goes to GAP if the macro is defined, otherwise to IDLE with `note_done`=1 for that cycle.
- `req_dur`=0: no PLAY cycles. The state goes to GAP or IDLE on the edge after acceptance; `note_done` is pulsed at the same point as for a normal note (on entry to IDLE without the macro, at the end of GAP with it).
- `abort`, any state: next state is IDLE, `speaker`=0, counters are cleared, and no `note_done` pulse. If `abort` and `req_valid` are high in the same cycle, abort wins and the request is not accepted.
- `busy` = (state != IDLE).

## Timing
- During reset: `speaker`, `busy`, `note_done` and `req_ready` are 0, and the state is IDLE.
- `req_ready` is 1 in the first cycle after `rst_n` rises.
- Reset asserted mid-note takes effect at the next edge; the note is discarded.
- For acceptance at edge E0:
  - `busy`=1 and `req_ready`=0 from E0.
  - The first `speaker` rise is at E0+H.
  - PLAY lasts exactly `req_dur`·TICK_DIV cycles.
- Without the macro, `note_done` and `req_ready` rise on the same edge. A new request can be accepted that very edge, so back-to-back notes have no dead cycle.
- An octave change takes effect only on the next accepted request.

## Configuration
- `TONE_GAP_EN` defined:
  - After PLAY, GAP holds `speaker`=0 and `busy`=1 for GAP_TICKS ticks.
  - `note_done` is then pulsed on entry to IDLE.
  - `abort` during GAP returns to IDLE with no pulse.
- Not defined: GAP state and its counter are removed; notes are legato.

## Structure
- Package `tone_pkg`:
  - Note code constants (REST, DO..SI).
  - Base half-period table at 100 MHz: 191113, 170262, 151686, 143172, 127551, 113636, 101238.
  - State enum.
- Sub-module `tone_tick_gen`: TICK_DIV prescaler with synchronous clear. It emits the one-cycle `tick` used by both the PLAY and GAP duration counters.

## Test plan
All scenarios use SIM_DIV_SHIFT=10 and TICK_DIV=1000, so do gives H=186.
- note=1, oct=0, dur=3 → `speaker` period 372 clocks; PLAY lasts 3000 clocks; `note_done` pulses once; `speaker` ends 0.
- note=1 with oct=+1, then oct=−1 → periods 186 and 744; oct=−4 on si (H=98<<4=1568) → period 3136, no saturation.
- note=0, dur=2 → `speaker` stays 0 for 2000 clocks, then `note_done`.
- Two requests held valid back-to-back (no macro) → second accepted on the `note_done` edge; zero idle cycles between notes.
- `abort` at cycle 500 of a note, with `req_valid` also high → IDLE next cycle, `speaker`=0, no `note_done`, request not accepted.
- `rst_n` low mid-note for 1 cycle → all outputs 0; `req_ready`=1 on the next cycle. Also dur=0 → `note_done` one cycle after acceptance, no `speaker` toggles.
